l1_cache_2way: RTL and testbench

//  Two-way set-associative, write-back, write-allocate L1 data cache between the CPU memory stage and DRAM.

---
 rtl/l1_cache_pkg.sv | 25 ++
 rtl/l1_cache_way.sv | 74 +++++++
 rtl/l1_cache_2way.sv | 207 ++++++++++++++++++++
 tb/tb_l1_cache_2way.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_cache_pkg.sv
// ----------------------------------------------------------------------------
// l1_cache_pkg
//   Shared types and default geometry for the two-way L1 data cache.
//   - state_t     : controller states (IDLE, WRITEBACK, ALLOCATE)
//   - default parameter values and the widths derived from them
//     (OFF_W byte-offset bits, IDX_W set-index bits, TAG_W tag bits)
// ----------------------------------------------------------------------------
package l1_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int ADDR_WIDTH     = 32;
    localparam int CPU_DATA_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 256;
    localparam int SETS           = 32;

    localparam int OFF_W = $clog2(MEM_DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;

endpackage

// File: rtl/l1_cache_way.sv
// ----------------------------------------------------------------------------
// l1_cache_way
//   One way of the cache: valid/dirty bit arrays (async reset), tag and line
//   arrays (not reset). Reads are combinational at 'idx'.
//   Ports:
//     clk, rst                      clock, async active-high reset
//     idx                           set index for read and both write ports
//     valid, dirty, tag, line       combinational read of set 'idx'
//     word_we, word_sel, word_data  single-word write; marks the set dirty
//     fill_we, fill_tag, fill_line  full-line refill; valid=1, dirty=0
//   Word k of a line lives at bits [line_w-1-k*word_w -: word_w].
// ----------------------------------------------------------------------------
module l1_cache_way #(
    parameter int tag_w  = 22,
    parameter int idx_w  = 5,
    parameter int line_w = 256,
    parameter int word_w = 32,
    parameter int wsel_w = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [idx_w-1:0]  idx,
    output logic              valid,
    output logic              dirty,
    output logic [tag_w-1:0]  tag,
    output logic [line_w-1:0] line,
    input  logic              word_we,
    input  logic [wsel_w-1:0] word_sel,
    input  logic [word_w-1:0] word_data,
    input  logic              fill_we,
    input  logic [tag_w-1:0]  fill_tag,
    input  logic [line_w-1:0] fill_line
);

    localparam int sets  = 1 << idx_w;
    localparam int words = line_w / word_w;

    logic [sets-1:0]   valid_q;
    logic [sets-1:0]   dirty_q;
    logic [tag_w-1:0]  tag_mem  [sets];
    logic [line_w-1:0] data_mem [sets];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_mem[idx];
    assign line  = data_mem[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid_q guards their contents.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[idx]  <= fill_tag;
            data_mem[idx] <= fill_line;
        end else if (word_we) begin
            for (int k = 0; k < words; k++) begin
                if (int'(word_sel) == k) begin
                    data_mem[idx][line_w-1-k*word_w -: word_w] <= word_data;
                end
            end
        end
    end

endmodule

// File: rtl/l1_cache_2way.sv
// ----------------------------------------------------------------------------
// l1_cache_2way
//   Two-way set-associative, write-back, write-allocate L1 data cache.
//   Hits ack in the same cycle; a miss optionally writes back a dirty victim
//   and then refills the line, after which the held request hits.
//   Ports:
//     clk, rst                    clock, async active-high reset
//     cache_addr/cs/we/data_i     CPU request, held until cache_ack
//     cache_ack, cache_data_o     completion and read data (0 when no ack)
//     dram_addr/cs/we/data_o      DRAM line request, held until dram_ack
//     dram_ack, dram_data_i       DRAM completion pulse and refill line
//     dbg_state                   current controller state
//   Handshakes: a request is presented by raising *_cs with its qualifiers
//   and is held unchanged until the matching ack pulses for one cycle; the
//   transfer happens in that ack cycle.
// ----------------------------------------------------------------------------
module l1_cache_2way
    import l1_cache_pkg::*;
#(
    parameter int addr_width     = ADDR_WIDTH,
    parameter int cpu_data_width = CPU_DATA_WIDTH,
    parameter int mem_data_width = MEM_DATA_WIDTH,
    parameter int sets           = SETS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [addr_width-1:0]     cache_addr,
    input  logic                      cache_cs,
    input  logic                      cache_we,
    output logic                      cache_ack,
    input  logic [cpu_data_width-1:0] cache_data_i,
    output logic [cpu_data_width-1:0] cache_data_o,
    output logic [addr_width-1:0]     dram_addr,
    output logic                      dram_cs,
    output logic                      dram_we,
    input  logic                      dram_ack,
    input  logic [mem_data_width-1:0] dram_data_i,
    output logic [mem_data_width-1:0] dram_data_o,
    output state_t                    dbg_state
);

    localparam int off_w  = $clog2(mem_data_width / 8);
    localparam int idx_w  = $clog2(sets);
    localparam int tag_w  = addr_width - idx_w - off_w;
    localparam int wsel_w = off_w - 2;

    // Address fields
    logic [tag_w-1:0]  addr_tag;
    logic [idx_w-1:0]  addr_idx;
    logic [wsel_w-1:0] wsel;
    logic [1:0]        unused_byte_off;

    assign addr_tag        = cache_addr[addr_width-1 -: tag_w];
    assign addr_idx        = cache_addr[off_w +: idx_w];
    assign wsel            = cache_addr[off_w-1:2];
    assign unused_byte_off = cache_addr[1:0];

    // Controller registers
    state_t            state;
    logic              victim_q;
    logic [tag_w-1:0]  miss_tag_q;
    logic [idx_w-1:0]  miss_idx_q;
    logic [sets-1:0]   lru;

    assign dbg_state = state;

    // Way interface
    logic [idx_w-1:0]          rd_idx;
    logic [1:0]                way_valid;
    logic [1:0]                way_dirty;
    logic [tag_w-1:0]          way_tag  [2];
    logic [mem_data_width-1:0] way_line [2];
    logic [1:0]                word_we;
    logic [1:0]                fill_we;

    // While a miss is in flight the arrays are addressed by the captured
    // index, so a CPU that drops or changes its request cannot disturb it.
    assign rd_idx = (state == IDLE) ? addr_idx : miss_idx_q;

    for (genvar w = 0; w < 2; w++) begin : g_way
        l1_cache_way #(
            .tag_w  (tag_w),
            .idx_w  (idx_w),
            .line_w (mem_data_width),
            .word_w (cpu_data_width),
            .wsel_w (wsel_w)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .idx       (rd_idx),
            .valid     (way_valid[w]),
            .dirty     (way_dirty[w]),
            .tag       (way_tag[w]),
            .line      (way_line[w]),
            .word_we   (word_we[w]),
            .word_sel  (wsel),
            .word_data (cache_data_i),
            .fill_we   (fill_we[w]),
            .fill_tag  (miss_tag_q),
            .fill_line (dram_data_i)
        );
    end

    // Hit detection
    logic [1:0] hit_vec;
    logic       hit;
    logic       miss;
    logic       hit_way;
    logic       victim_sel;

    assign hit_vec[0] = way_valid[0] && (way_tag[0] == addr_tag);
    assign hit_vec[1] = way_valid[1] && (way_tag[1] == addr_tag);
    assign hit        = (state == IDLE) && cache_cs && (|hit_vec);
    assign miss       = (state == IDLE) && cache_cs && !(|hit_vec);
    assign hit_way    = hit_vec[0] ? 1'b0 : 1'b1;

    // Fill an empty way first (way 0 preferred), otherwise evict the LRU way.
    assign victim_sel = !way_valid[0] ? 1'b0 :
                        !way_valid[1] ? 1'b1 : lru[addr_idx];

    always_comb begin
        word_we = '0;
        fill_we = '0;
        if (hit && cache_we) begin
            word_we[hit_way] = 1'b1;
        end
        if ((state == ALLOCATE) && dram_ack) begin
            fill_we[victim_q] = 1'b1;
        end
    end

    // Controller FSM and LRU update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            victim_q   <= 1'b0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            lru        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        // lru names the next victim: the way not just used.
                        lru[addr_idx] <= ~hit_way;
                    end else if (miss) begin
                        victim_q   <= victim_sel;
                        miss_tag_q <= addr_tag;
                        miss_idx_q <= addr_idx;
                        if (way_valid[victim_sel] && way_dirty[victim_sel]) begin
                            state <= WRITEBACK;
                        end else begin
                            state <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (dram_ack) begin
                        state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (dram_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CPU-side outputs
    logic [mem_data_width-1:0] hit_line;

    assign cache_ack = hit;

    always_comb begin
        hit_line     = way_line[hit_way];
        cache_data_o = '0;
        if (hit) begin
            cache_data_o = hit_line[mem_data_width-1 - int'(wsel)*cpu_data_width -: cpu_data_width];
        end
    end

    // DRAM-side outputs, decoded from the state register so reset clears
    // dram_cs/dram_we immediately.
    always_comb begin
        dram_cs     = 1'b0;
        dram_we     = 1'b0;
        dram_addr   = '0;
        dram_data_o = '0;
        case (state)
            WRITEBACK: begin
                dram_cs     = 1'b1;
                dram_we     = 1'b1;
                dram_addr   = {way_tag[victim_q], miss_idx_q, {off_w{1'b0}}};
                dram_data_o = way_line[victim_q];
            end
            ALLOCATE: begin
                dram_cs   = 1'b1;
                dram_addr = {miss_tag_q, miss_idx_q, {off_w{1'b0}}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_cache_2way.sv
// ----------------------------------------------------------------------------
// tb_l1_cache_2way
//   Directed bench for l1_cache_2way. DUT a uses default geometry, DUT b uses
//   sets=64 / 128-bit lines. Each DRAM model acks 3 cycles after dram_cs and
//   returns line(A) with word k = 0xA0000000 + A + k.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l1_cache_2way;
    import l1_cache_pkg::*;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT a signals
    logic [31:0]  cache_addr = '0;
    logic         cache_cs = 1'b0;
    logic         cache_we = 1'b0;
    logic         cache_ack;
    logic [31:0]  cache_data_i = '0;
    logic [31:0]  cache_data_o;
    logic [31:0]  dram_addr;
    logic         dram_cs;
    logic         dram_we;
    logic         dram_ack = 1'b0;
    logic [255:0] dram_data_i = '0;
    logic [255:0] dram_data_o;
    state_t       dbg_state;

    // DUT b signals
    logic [31:0]  b_cache_addr = '0;
    logic         b_cache_cs = 1'b0;
    logic         b_cache_ack;
    logic [31:0]  b_cache_data_o;
    logic [31:0]  b_dram_addr;
    logic         b_dram_cs;
    logic         b_dram_we;
    logic         b_dram_ack = 1'b0;
    logic [127:0] b_dram_data_i = '0;
    logic [127:0] b_dram_data_o;
    state_t       b_dbg_state;

    l1_cache_2way u_dut_a (
        .clk(clk), .rst(rst),
        .cache_addr(cache_addr), .cache_cs(cache_cs), .cache_we(cache_we),
        .cache_ack(cache_ack), .cache_data_i(cache_data_i), .cache_data_o(cache_data_o),
        .dram_addr(dram_addr), .dram_cs(dram_cs), .dram_we(dram_we),
        .dram_ack(dram_ack), .dram_data_i(dram_data_i), .dram_data_o(dram_data_o),
        .dbg_state(dbg_state)
    );

    l1_cache_2way #(.mem_data_width(128), .sets(64)) u_dut_b (
        .clk(clk), .rst(rst),
        .cache_addr(b_cache_addr), .cache_cs(b_cache_cs), .cache_we(1'b0),
        .cache_ack(b_cache_ack), .cache_data_i(32'h0), .cache_data_o(b_cache_data_o),
        .dram_addr(b_dram_addr), .dram_cs(b_dram_cs), .dram_we(b_dram_we),
        .dram_ack(b_dram_ack), .dram_data_i(b_dram_data_i), .dram_data_o(b_dram_data_o),
        .dbg_state(b_dbg_state)
    );

    // Scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0]  exp_q[$];
    logic [31:0]  wb_addr_q[$];
    logic [255:0] wb_data_q[$];
    logic [31:0]  rf_addr_q[$];
    logic [31:0]  b_rf_addr_q[$];
    int cnt_a = 0;
    int cnt_b = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line_a(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[255-k*32 -: 32] = 32'hA000_0000 + a + k;
        return l;
    endfunction

    function automatic logic [127:0] line_b(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[127-k*32 -: 32] = 32'hA000_0000 + a + k;
        return l;
    endfunction

    // DRAM models: count negedges with dram_cs high, ack on the third.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            dram_ack = 1'b0;
            cnt_a = 0;
        end else if (dram_ack) begin
            dram_ack = 1'b0;
            cnt_a = 0;
        end else if (dram_cs) begin
            cnt_a++;
            if (cnt_a == 3) begin
                dram_ack = 1'b1;
                if (dram_we) begin
                    wb_addr_q.push_back(dram_addr);
                    wb_data_q.push_back(dram_data_o);
                end else begin
                    rf_addr_q.push_back(dram_addr);
                    dram_data_i = line_a(dram_addr);
                end
            end
        end else begin
            cnt_a = 0;
        end
    end

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            b_dram_ack = 1'b0;
            cnt_b = 0;
        end else if (b_dram_ack) begin
            b_dram_ack = 1'b0;
            cnt_b = 0;
        end else if (b_dram_cs) begin
            cnt_b++;
            if (cnt_b == 3) begin
                b_dram_ack = 1'b1;
                if (!b_dram_we) begin
                    b_rf_addr_q.push_back(b_dram_addr);
                    b_dram_data_i = line_b(b_dram_addr);
                end
            end
        end else begin
            cnt_b = 0;
        end
    end

    // Driver tasks: called just after a negedge; leave cs high on return.
    task automatic cpu_access(input string tag, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        cache_addr = addr; cache_we = we; cache_data_i = wdata; cache_cs = 1'b1;
        lat = 0;
        #1;
        while (!cache_ack && lat < 60) begin
            @(negedge clk); #1;
            lat++;
        end
        check({tag, "_ack"}, cache_ack, 1);
        rdata = cache_data_o;
        @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp, output int lat);
        logic [31:0] rd;
        exp_q.push_back(exp);
        cpu_access(tag, addr, 1'b0, 32'h0, rd, lat);
        check({tag, "_data"}, rd, exp_q.pop_front());
    endtask

    task automatic cpu_idle();
        cache_cs = 1'b0;
        cache_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        wb_addr_q.delete();
        wb_data_q.delete();
        rf_addr_q.delete();
    endtask

    task automatic do_reset();
        cache_cs = 1'b0;
        b_cache_cs = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
    endtask

    initial begin : main
        logic [31:0] rd;
        int lat;

        // Reset state
        @(negedge clk); #1;
        check("rst_cache_ack", cache_ack, 0);
        check("rst_dram_cs", dram_cs, 0);
        check("rst_dram_we", dram_we, 0);
        check("rst_data_o", cache_data_o, 0);
        check("rst_dram_data_o", dram_data_o, 0);
        check("rst_state", dbg_state, IDLE);
        do_reset();

        // 1: cold read 0x44 -> refill 0x40, word 1 returned
        rd_check("t1_rd44", 32'h44, 32'hA000_0041, lat);
        check("t1_missed", lat != 0, 1);
        check("t1_rf_cnt", rf_addr_q.size(), 1);
        check("t1_rf_addr", rf_addr_q[0], 32'h40);
        check("t1_wb_cnt", wb_addr_q.size(), 0);

        // 2: write hit at 0x40, back-to-back read
        cpu_access("t2_wr40", 32'h40, 1'b1, 32'hDEAD_BEEF, rd, lat);
        check("t2_wr_lat", lat, 0);
        rd_check("t2_rd40", 32'h40, 32'hDEAD_BEEF, lat);
        check("t2_rd_lat", lat, 0);
        rd_check("t2_rd44", 32'h44, 32'hA000_0041, lat);
        cpu_idle();
        #1;
        check("t2_idle_data_o", cache_data_o, 0);

        // 3: 0x440 fills way 1 clean; 0x840 evicts dirty 0x40
        clear_logs();
        rd_check("t3_rd440", 32'h440, 32'hA000_0440, lat);
        check("t3_440_wb_cnt", wb_addr_q.size(), 0);
        check("t3_440_rf_addr", rf_addr_q[0], 32'h440);
        clear_logs();
        rd_check("t3_rd840", 32'h840, 32'hA000_0840, lat);
        check("t3_wb_cnt", wb_addr_q.size(), 1);
        check("t3_wb_addr", wb_addr_q[0], 32'h40);
        check("t3_wb_w0", wb_data_q[0][255 -: 32], 32'hDEAD_BEEF);
        check("t3_wb_w1", wb_data_q[0][223 -: 32], 32'hA000_0041);
        check("t3_rf_addr", rf_addr_q[0], 32'h840);
        rd_check("t3_rd440_hit", 32'h440, 32'hA000_0440, lat);
        check("t3_440_hit_lat", lat, 0);
        cpu_idle();

        // 4: LRU picks way 1 after a hit on way 0
        do_reset();
        rd_check("t4_rd40", 32'h40, 32'hA000_0040, lat);
        rd_check("t4_rd440", 32'h440, 32'hA000_0440, lat);
        rd_check("t4_rd40_hit", 32'h40, 32'hA000_0040, lat);
        check("t4_hit_lat", lat, 0);
        clear_logs();
        rd_check("t4_rd840", 32'h840, 32'hA000_0840, lat);
        check("t4_wb_cnt", wb_addr_q.size(), 0);
        check("t4_rf_addr", rf_addr_q[0], 32'h840);
        rd_check("t4_rd40_still", 32'h48, 32'hA000_0042, lat);
        check("t4_still_lat", lat, 0);
        rd_check("t4_rd440_gone", 32'h440, 32'hA000_0440, lat);
        check("t4_440_missed", lat != 0, 1);
        cpu_idle();

        // 5: async reset during write-back
        do_reset();
        cpu_access("t5_wr40", 32'h40, 1'b1, 32'h1111_2222, rd, lat);
        cpu_access("t5_wr440", 32'h440, 1'b1, 32'h3333_4444, rd, lat);
        cpu_idle();
        cache_addr = 32'h840; cache_we = 1'b0; cache_cs = 1'b1;
        lat = 0;
        while (!(dram_cs && dram_we) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t5_in_wb", dram_we, 1);
        check("t5_wb_state", dbg_state, WRITEBACK);
        rst = 1'b1;
        #1;
        check("t5_rst_dram_cs", dram_cs, 0);
        check("t5_rst_dram_we", dram_we, 0);
        check("t5_rst_state", dbg_state, IDLE);
        cache_cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        rd_check("t5_rd40", 32'h40, 32'hA000_0040, lat);
        check("t5_missed", lat != 0, 1);
        check("t5_wb_cnt", wb_addr_q.size(), 0);
        check("t5_rf_addr", rf_addr_q[0], 32'h40);
        cpu_idle();

        // 6: 64 sets, 128-bit lines: 0x3F4 -> line 0x3F0, idx 63, word 1
        b_cache_addr = 32'h3F4;
        b_cache_cs = 1'b1;
        lat = 0;
        #1;
        while (!b_cache_ack && lat < 60) begin
            if (b_dram_cs) check("t6_dram_addr", b_dram_addr, 32'h3F0);
            @(negedge clk); #1;
            lat++;
        end
        check("t6_ack", b_cache_ack, 1);
        check("t6_data", b_cache_data_o, 32'hA000_03F1);
        check("t6_rf_cnt", b_rf_addr_q.size(), 1);
        check("t6_idx63", u_dut_b.miss_idx_q, 63);
        @(negedge clk);
        b_cache_addr = 32'h3F8;
        #1;
        check("t6_hit_ack", b_cache_ack, 1);
        check("t6_hit_data", b_cache_data_o, 32'hA000_03F2);
        @(negedge clk);
        b_cache_cs = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
